// File: rtl/pipe_cla_pkg.sv
// Shared types and constants for the pipelined CLA adder/subtractor.
// Op encodings, lookahead group size and per-stage control payload.
package pipe_cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int CLA_GRP = 4;

  // Control half of a stage payload. The data half (a/b delay lines
  // and the skewed sum) depends on WIDTH and is built in the top.
  typedef struct packed {
    logic valid;
    logic carry;
    logic zero;
    logic ovf;
  } stg_ctl_t;

endpackage

// File: rtl/pipe_cla_addsub_cla_seg.sv
// cla_seg: combinational SEG-bit adder built from 4-bit lookahead groups.
// Ports: a, b, cin in; sum, cout (carry out of MSB), c_msb (carry into MSB).
module cla_seg
  import pipe_cla_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  localparam int NG = SEG / CLA_GRP;

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Full lookahead inside each group; group carries chain between groups.
  always_comb begin
    int base;
    c    = '0;
    c[0] = cin;
    for (int j = 0; j < NG; j++) begin
      base = j * CLA_GRP;
      c[base+1] = g[base]
                | (p[base] & c[base]);
      c[base+2] = g[base+1]
                | (p[base+1] & g[base])
                | (p[base+1] & p[base] & c[base]);
      c[base+3] = g[base+2]
                | (p[base+2] & g[base+1])
                | (p[base+2] & p[base+1] & g[base])
                | (p[base+2] & p[base+1] & p[base]
                   & c[base]);
      c[base+4] = g[base+3]
                | (p[base+3] & g[base+2])
                | (p[base+3] & p[base+2] & g[base+1])
                | (p[base+3] & p[base+2] & p[base+1]
                   & g[base])
                | (p[base+3] & p[base+2] & p[base+1]
                   & p[base] & c[base]);
    end
  end

  assign sum   = p ^ c[SEG-1:0];
  assign cout  = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined CLA add/sub, one SEG-bit segment per stage, valid/ready both
// sides. Ports: clk, rst_n, in_valid/in_ready/in_a/in_b/in_cin/in_op,
// out_valid/out_ready/out_sum/out_cout/out_ovf/out_zero.
// Optional macro PIPE_CLA_SATURATE_EN clamps the result on signed overflow.
module pipe_cla_addsub
  import pipe_cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSTG = WIDTH / SEG;

  typedef struct packed {
    stg_ctl_t         ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stg_t;

  stg_t pipe [NSTG];
  stg_t last;
  logic stall;

  assign last     = pipe[NSTG-1];
  assign stall    = last.ctl.valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    stg_t           src;
    stg_t           nxt;
    stg_t           st;
    logic [SEG-1:0] s;
    logic           co;
    logic           cm;

    // B is inverted once at entry so every stage just adds.
    if (k == 0) begin : g_in
      always_comb begin
        src           = '0;
        src.ctl.valid = in_valid;
        src.ctl.carry = (in_op == OP_SUB) ? 1'b1 : in_cin;
        src.ctl.zero  = 1'b1;
        src.a         = in_a;
        src.b         = (in_op == OP_SUB) ? ~in_b : in_b;
      end
    end else begin : g_chain
      assign src = pipe[k-1];
    end

    cla_seg #(
      .SEG (SEG)
    ) u_seg (
      .a     (src.a[k*SEG +: SEG]),
      .b     (src.b[k*SEG +: SEG]),
      .cin   (src.ctl.carry),
      .sum   (s),
      .cout  (co),
      .c_msb (cm)
    );

    always_comb begin
      nxt                  = src;
      nxt.sum[k*SEG +: SEG] = s;
      nxt.ctl.carry        = co;
      nxt.ctl.zero         = src.ctl.zero && (s == '0);
      nxt.ctl.ovf          = 1'b0;
      if (k == NSTG - 1) begin
        nxt.ctl.ovf = cm ^ co;
`ifdef PIPE_CLA_SATURATE_EN
        // Clamped values are never zero, so zero drops with the clamp.
        if (nxt.ctl.ovf) begin
          nxt.sum = src.a[WIDTH-1]
                  ? {1'b1, {(WIDTH-1){1'b0}}}
                  : {1'b0, {(WIDTH-1){1'b1}}};
          nxt.ctl.zero = 1'b0;
        end
`endif
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st <= '0;
      end else if (!stall) begin
        st <= nxt;
      end
    end

    assign pipe[k] = st;

    if (k != NSTG - 1) begin : g_mid
      logic unused_cm;
      assign unused_cm = cm;
    end
  end

  // Operand delay lines are fully consumed by the last stage.
  logic unused_tail;
  assign unused_tail = ^{last.a, last.b};

  assign out_valid = last.ctl.valid;
  assign out_sum   = last.sum;
  assign out_cout  = last.ctl.carry;
  assign out_ovf   = last.ctl.ovf;
  assign out_zero  = last.ctl.zero;

endmodule
